// File: rtl/freq_ctrl_pkg.sv
// Shared constants and encodings for the front-panel frequency control.
// Timing defaults assume a 50 MHz sysclk.
package freq_ctrl_pkg;

    localparam int DEB_CYCLES_50M   = 500000;
    localparam int REPEAT_DELAY_50M = 25000000;
    localparam int REPEAT_RATE_50M  = 5000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer.
// The debounced level flips after DEB_CYCLES consecutive disagreeing samples.
module btn_debounce
    import freq_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_50M
) (
    input  logic sysclk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/freq_step_ctrl.sv
// Plus/minus button handling with press-step, auto-repeat and a
// saturating frequency index for the waveform stage.
module freq_step_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_50M,
    parameter int REPEAT_DELAY = REPEAT_DELAY_50M,
    parameter int REPEAT_RATE  = REPEAT_RATE_50M,
    parameter int IDX_W        = 5,
    parameter int IDX_MAX      = 31,
    parameter int IDX_RESET    = 8
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             Bt_Plus,
    input  logic             Bt_Minus,
    output logic [IDX_W-1:0] freq_idx,
    output logic             step_pulse,
    output logic             at_min,
    output logic             at_max
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic deb_plus;
    logic deb_minus;
    logic plus_only;
    logic minus_only;
    logic held_ok;
    logic delay_done;
    logic rate_done;

    state_e state_q, state_d;
    dir_e   dir_q, dir_d;
    dir_e   step_dir_q, step_dir_d;
    logic   step_q, step_d;
    logic   pulse_q, pulse_d;

    logic [RCW-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_plus (
        .sysclk (sysclk),
        .reset  (reset),
        .raw    (Bt_Plus),
        .deb    (deb_plus)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_minus (
        .sysclk (sysclk),
        .reset  (reset),
        .raw    (Bt_Minus),
        .deb    (deb_minus)
    );

    assign plus_only  = deb_plus & ~deb_minus;
    assign minus_only = deb_minus & ~deb_plus;
    assign held_ok    = (dir_q == UP) ? plus_only : minus_only;
    assign delay_done = (cnt_q == RCW'(REPEAT_DELAY - 1));
    assign rate_done  = (cnt_q == RCW'(REPEAT_RATE - 1));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= UP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (plus_only | minus_only) begin
                    state_d = HOLD;
                    dir_d   = plus_only ? UP : DOWN;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!held_ok) begin
                    state_d = IDLE;
                end else if (delay_done) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + RCW'(1);
                end
            end
            REPEAT: begin
                if (!held_ok) begin
                    state_d = IDLE;
                end else if (rate_done) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + RCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Step requests are registered, so the index moves one cycle later.
    always_comb begin
        step_d     = 1'b0;
        step_dir_d = dir_q;
        unique case (state_q)
            IDLE: begin
                step_d     = plus_only | minus_only;
                step_dir_d = plus_only ? UP : DOWN;
            end
            HOLD:    step_d = held_ok & delay_done;
            REPEAT:  step_d = held_ok & rate_done;
            default: step_d = 1'b0;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        pulse_d = 1'b0;
        if (step_q) begin
            if (step_dir_q == UP && idx_q != IDX_W'(IDX_MAX)) begin
                idx_d   = idx_q + IDX_W'(1);
                pulse_d = 1'b1;
            end else if (step_dir_q == DOWN && idx_q != '0) begin
                idx_d   = idx_q - IDX_W'(1);
                pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            step_q     <= 1'b0;
            step_dir_q <= UP;
            idx_q      <= IDX_W'(IDX_RESET);
            pulse_q    <= 1'b0;
        end else begin
            step_q     <= step_d;
            step_dir_q <= step_dir_d;
            idx_q      <= idx_d;
            pulse_q    <= pulse_d;
        end
    end

    assign freq_idx   = idx_q;
    assign step_pulse = pulse_q;
    assign at_min     = (idx_q == '0);
    assign at_max     = (idx_q == IDX_W'(IDX_MAX));

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Bench for freq_step_ctrl: scenario tasks checked against an
// event-level model of press timing and saturating index arithmetic.
module tb_freq_step_ctrl;

    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RR   = 8;
    localparam int MAXI = 31;
    localparam int RSTI = 8;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       Bt_Plus = 1'b0;
    logic       Bt_Minus = 1'b0;
    logic [4:0] freq_idx;
    logic       step_pulse;
    logic       at_min;
    logic       at_max;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int   m_idx;
    logic m_pulse;
    logic m_pend;
    logic m_pend_up;
    int   m_act;
    int   m_t;
    logic m_deb [2];
    int   m_run [2];
    logic m_d1  [2];
    logic m_d2  [2];

    freq_step_ctrl #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .IDX_W        (5),
        .IDX_MAX      (MAXI),
        .IDX_RESET    (RSTI)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .Bt_Plus    (Bt_Plus),
        .Bt_Minus   (Bt_Minus),
        .freq_idx   (freq_idx),
        .step_pulse (step_pulse),
        .at_min     (at_min),
        .at_max     (at_max)
    );

    always #5 sysclk = ~sysclk;

    // One clock edge of the reference: the index applies last edge's step
    // decision, the decision uses hold time since the first step, and the
    // debounced level flips after DEB consecutive disagreeing samples seen
    // through a two-cycle delay line.
    task automatic model_update(input logic r, input logic bp, input logic bm);
        logic p, m;
        if (r) begin
            m_idx = RSTI; m_pulse = 1'b0; m_pend = 1'b0; m_pend_up = 1'b0;
            m_act = 0; m_t = 0;
            for (int b = 0; b < 2; b++) begin
                m_deb[b] = 1'b0; m_run[b] = 0; m_d1[b] = 1'b0; m_d2[b] = 1'b0;
            end
            return;
        end
        m_pulse = 1'b0;
        if (m_pend) begin
            if (m_pend_up && m_idx < MAXI) begin
                m_idx++; m_pulse = 1'b1;
            end else if (!m_pend_up && m_idx > 0) begin
                m_idx--; m_pulse = 1'b1;
            end
        end
        p = m_deb[0] & ~m_deb[1];
        m = m_deb[1] & ~m_deb[0];
        m_pend = 1'b0;
        if (m_act == 0) begin
            if (p || m) begin
                m_act = p ? 1 : 2; m_t = 0; m_pend = 1'b1; m_pend_up = p;
            end
        end else if ((m_act == 1 && p) || (m_act == 2 && m)) begin
            m_t++;
            if (m_t == RD || (m_t > RD && (m_t - RD) % RR == 0)) begin
                m_pend = 1'b1; m_pend_up = (m_act == 1);
            end
        end else begin
            m_act = 0;
        end
        for (int b = 0; b < 2; b++) begin
            if (m_d2[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_deb[b] = ~m_deb[b]; m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
            m_d2[b] = m_d1[b];
        end
        m_d1[0] = bp;
        m_d1[1] = bm;
    endtask

    task automatic cycle(input logic r, input logic bp, input logic bm);
        reset = r; Bt_Plus = bp; Bt_Minus = bm;
        @(posedge sysclk);
        model_update(r, bp, bm);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (freq_idx !== 5'd8) begin
            n_bad++; $display("FAIL reset_idx got %0d want 8", freq_idx);
        end
        n_cmp++;
        if (step_pulse !== 1'b0) begin
            n_bad++; $display("FAIL reset_pulse got %b want 0", step_pulse);
        end
        n_cmp++;
        if (at_min !== 1'b0 || at_max !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got min=%b max=%b want 0/0", at_min, at_max);
        end
    endtask

    task automatic test_clean_press();
        int pulse_at = -1;
        int npulse = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, (i < 10), 1'b0);
            n_cmp++;
            if (freq_idx !== m_idx[4:0] || step_pulse !== m_pulse ||
                at_min !== (m_idx == 0) || at_max !== (m_idx == MAXI)) begin
                n_bad++;
                $display("FAIL press_trace cyc=%0d got idx=%0d p=%b want idx=%0d p=%b",
                         i, freq_idx, step_pulse, m_idx, m_pulse);
            end
            if (step_pulse === 1'b1) begin
                npulse++; pulse_at = i;
            end
        end
        n_cmp++;
        if (pulse_at !== 7 || npulse !== 1) begin
            n_bad++;
            $display("FAIL press_latency got at=%0d n=%0d want at=7 n=1", pulse_at, npulse);
        end
        n_cmp++;
        if (freq_idx !== 5'd9) begin
            n_bad++; $display("FAIL press_idx got %0d want 9", freq_idx);
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (freq_idx !== 5'd10) begin
            n_bad++; $display("FAIL repress_idx got %0d want 10", freq_idx);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bounce();
        int npulse = 0;
        logic lvl = 1'b1;
        int run;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, (((i / 2) % 2) == 0) && (i < 20), 1'b0);
            if (step_pulse === 1'b1) npulse++;
        end
        run = $urandom_range(1, DEB - 1);
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, lvl, 1'b0);
            if (step_pulse === 1'b1) npulse++;
            if (--run == 0) begin
                lvl = ~lvl; run = $urandom_range(1, DEB - 1);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (step_pulse === 1'b1) npulse++;
        end
        n_cmp++;
        if (npulse !== 0 || freq_idx !== 5'd8) begin
            n_bad++;
            $display("FAIL bounce got pulses=%0d idx=%0d want 0/8", npulse, freq_idx);
        end
    endtask

    task automatic test_repeat_down();
        int exp_rel [7] = '{0, 20, 28, 36, 44, 52, 60};
        int rel [$];
        int t0 = -1;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (freq_idx !== m_idx[4:0] || step_pulse !== m_pulse ||
                at_min !== (m_idx == 0) || at_max !== (m_idx == MAXI)) begin
                n_bad++;
                $display("FAIL repeat_trace cyc=%0d got idx=%0d p=%b want idx=%0d p=%b",
                         i, freq_idx, step_pulse, m_idx, m_pulse);
            end
            if (step_pulse === 1'b1) begin
                if (t0 < 0) t0 = i;
                rel.push_back(i - t0);
            end
            if (t0 >= 0 && i - t0 >= 60) break;
        end
        n_cmp++;
        if (t0 < 0 || rel.size() != 7) begin
            n_bad++;
            $display("FAIL repeat_count got %0d steps want 7", rel.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                n_cmp++;
                if (rel[k] !== exp_rel[k]) begin
                    n_bad++;
                    $display("FAIL repeat_time step%0d got +%0d want +%0d", k, rel[k], exp_rel[k]);
                end
            end
        end
        n_cmp++;
        if (freq_idx !== 5'd1) begin
            n_bad++; $display("FAIL repeat_idx got %0d want 1", freq_idx);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturate_max();
        int npulse = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (freq_idx !== m_idx[4:0] || step_pulse !== m_pulse ||
                at_min !== (m_idx == 0) || at_max !== (m_idx == MAXI)) begin
                n_bad++;
                $display("FAIL sat_trace cyc=%0d got idx=%0d p=%b want idx=%0d p=%b",
                         i, freq_idx, step_pulse, m_idx, m_pulse);
            end
            if (step_pulse === 1'b1) npulse++;
        end
        n_cmp++;
        if (npulse !== 23) begin
            n_bad++; $display("FAIL sat_pulses got %0d want 23", npulse);
        end
        n_cmp++;
        if (freq_idx !== 5'd31 || at_max !== 1'b1 || at_min !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_idx got %0d max=%b min=%b want 31/1/0", freq_idx, at_max, at_min);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_both_pressed();
        int n_both = 0;
        int n_after = 0;
        do_reset();
        for (int i = 0; i < 61; i++) begin
            logic bp, bm;
            bp = (i < 39);
            bm = (i >= 9);
            cycle(1'b0, bp, bm);
            n_cmp++;
            if (freq_idx !== m_idx[4:0] || step_pulse !== m_pulse ||
                at_min !== (m_idx == 0) || at_max !== (m_idx == MAXI)) begin
                n_bad++;
                $display("FAIL both_trace cyc=%0d got idx=%0d p=%b want idx=%0d p=%b",
                         i, freq_idx, step_pulse, m_idx, m_pulse);
            end
            if (step_pulse === 1'b1) begin
                if (i >= 9 && i < 39) n_both++;
                if (i >= 39) n_after++;
            end
        end
        n_cmp++;
        if (n_both !== 0 || n_after !== 1 || freq_idx !== 5'd8) begin
            n_bad++;
            $display("FAIL both_steps got both=%0d after=%0d idx=%0d want 0/1/8",
                     n_both, n_after, freq_idx);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int pulse_at = -1;
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (freq_idx !== 5'd11) begin
            n_bad++; $display("FAIL midrst_pre got %0d want 11", freq_idx);
        end
        cycle(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (freq_idx !== 5'd8 || step_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_idx got %0d p=%b want 8/0", freq_idx, step_pulse);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            if (step_pulse === 1'b1 && pulse_at < 0) pulse_at = i;
        end
        n_cmp++;
        if (pulse_at !== 7 || freq_idx !== 5'd9) begin
            n_bad++;
            $display("FAIL midrst_fresh got at=%0d idx=%0d want 7/9", pulse_at, freq_idx);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic lv [2] = '{1'b0, 1'b0};
        int   rn [2] = '{1, 1};
        logic r;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (--rn[b] <= 0) begin
                    lv[b] = $urandom_range(0, 1);
                    rn[b] = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                          : $urandom_range(4, 120));
                end
            end
            r = ($urandom_range(0, 299) == 0);
            cycle(r, lv[0], lv[1]);
            n_cmp++;
            if (freq_idx !== m_idx[4:0] || step_pulse !== m_pulse ||
                at_min !== (m_idx == 0) || at_max !== (m_idx == MAXI)) begin
                n_bad++;
                $display("FAIL random_trace cyc=%0d got idx=%0d p=%b want idx=%0d p=%b",
                         i, freq_idx, step_pulse, m_idx, m_pulse);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat_down();
        test_saturate_max();
        test_both_pressed();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_step_ctrl.md
# freq_step_ctrl

Front-panel frequency control for the function generator. Synchronises and debounces the Bt_Plus / Bt_Minus push-buttons, produces one step on press plus auto-repeat while held, and maintains a saturating frequency index. The waveform/phase-accumulator stage downstream consumes that index to pick its tuning word.

## Interface
Parameters:
- DEB_CYCLES, 500000, consecutive cycles a synchronised button must differ from its debounced state before that state flips (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles from the first step to the first auto-repeat step (500 ms).
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeat steps (100 ms).
- IDX_W, 5, width of freq_idx.
- IDX_MAX, 31, upper saturation value of freq_idx.
- IDX_RESET, 8, value of freq_idx after reset.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Bt_Plus  in  1  raw, asynchronous, bouncy increment button, active-high.
- Bt_Minus  in  1  raw, asynchronous, bouncy decrement button, active-high.
- freq_idx  out  IDX_W  current frequency index.
- step_pulse  out  1  one-cycle strobe when freq_idx has just changed.
- at_min  out  1  freq_idx == 0.
- at_max  out  1  freq_idx == IDX_MAX.

## Operation
- Per button: 2-flop synchroniser, then debouncer. Debouncer counter clears whenever the synchronised input equals the debounced state. While they differ, the counter increments. When it reaches DEB_CYCLES-1, the debounced state flips and the counter clears.
- Define plus_only = deb_plus & ~deb_minus and minus_only = deb_minus & ~deb_plus.
- Repeat FSM, with states IDLE, HOLD and REPEAT, plus a repeat counter and a latched direction dir:
  - IDLE: on plus_only or minus_only, issue a step in that direction, latch dir, clear the counter, go to HOLD.
  - HOLD: if the latched button's *_only term deasserts (release, or the other button also pressed), go to IDLE with no step. If the counter reaches REPEAT_DELAY-1, issue a step, clear the counter, go to REPEAT. Otherwise increment the counter.
  - REPEAT: same exit condition as HOLD. If the counter reaches REPEAT_RATE-1, issue a step and clear the counter.
- Both buttons held: no steps. On returning to IDLE, if exactly one button remains held, that counts as a new press and steps immediately on the next cycle.
- Step arithmetic:
  - Up: freq_idx+1, saturating at IDX_MAX.
  - Down: freq_idx-1, saturating at 0.
  - No wrap-around.
  - A step requested at the limit leaves freq_idx unchanged and does not assert step_pulse. The FSM still follows its normal transitions.

## Timing
- Reset values:
  - freq_idx = IDX_RESET, step_pulse = 0.
  - at_min and at_max decoded from IDX_RESET.
  - FSM in IDLE; synchronisers, debounced states and all counters at 0.
- Reset mid-operation (buttons held) returns to these values. A still-held button is re-debounced and produces a fresh first step.
- Latency: a raw press edge sampled at edge N with no bounce gives:
  - debounced state high after edge N+DEB_CYCLES+1;
  - the FSM step decision in the following cycle;
  - freq_idx and step_pulse updated together after edge N+DEB_CYCLES+3.
- Release latency is the same; the FSM is in IDLE one cycle after the debounced fall.
- step_pulse is registered, high exactly one cycle, and coincides with the first cycle of the new freq_idx.
- at_min and at_max are combinational decodes of the registered freq_idx.
- Held button: steps at T0 (first), T0+REPEAT_DELAY, then every REPEAT_RATE cycles.
- Bounce shorter than DEB_CYCLES cycles produces no transition.

## Structure
- Shared package freq_ctrl_pkg:
  - default constants DEB_CYCLES_50M, REPEAT_DELAY_50M, REPEAT_RATE_50M;
  - FSM state encoding IDLE/HOLD/REPEAT;
  - direction encoding UP/DOWN.
- Sub-module btn_debounce, holding the synchroniser plus debouncer (parameter DEB_CYCLES; ports sysclk, reset, raw, deb), instantiated twice.
- FSM, repeat counter and index register live in the top.
- Counter widths are derived with $clog2 of each parameter.

## Test plan
Bench parameters: DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, IDX_W=5, IDX_MAX=31, IDX_RESET=8.
- Reset with both buttons low -> freq_idx=8, step_pulse=0, at_min=0, at_max=0.
- Clean Bt_Plus press at edge N, held 10 cycles -> freq_idx=9 and step_pulse high for one cycle at N+7; no further steps; release returns FSM to IDLE.
- Bt_Plus toggling every 2 cycles for 20 cycles, then low -> freq_idx stays 8, step_pulse never asserts.
- Bt_Minus held 60 cycles after its first step -> steps at +0, +20, +28, +36, +44, +52, +60; freq_idx=1.
- Index at 30, Bt_Plus held through repeats -> freq_idx=31, at_max=1; further repeats give no step_pulse and no wrap to 0.
- Bt_Plus held, then Bt_Minus added during HOLD -> no steps while both held. Release Bt_Plus -> after Bt_Plus debounces low, one down step.
- Reset asserted mid-REPEAT with Bt_Plus held -> freq_idx=8 next cycle; fresh first step after debounce.
